// File: rtl/systolic_feeder.sv
// Skewed operand feeder for one systolic-array edge: buffers up to DEPTH vectors and
// streams them with lane i delayed i cycles. Optional job replay: SYSTOLIC_FEEDER_REPLAY_EN.
module systolic_feeder #(
    parameter int LANES = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [LANES*DW-1:0]   wr_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [LANES*DW-1:0]   lane_out,
    output logic [LANES-1:0]      lane_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(DEPTH + LANES) + 1;

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_count;
    logic [SW-1:0]         r_step;
    logic [LANES*DW-1:0]   r_mem [DEPTH];
    logic                  r_busy;
    logic                  r_done;
    logic [LANES*DW-1:0]   r_lane_out;
    logic [LANES-1:0]      r_lane_valid;

    logic                  w_wr_ready;
    logic                  w_start_ok;
    logic                  w_clear;
    logic                  w_wr_en;
    logic                  w_last;
    logic [SW-1:0]         w_step_sel;
    logic [LANES*DW-1:0]   w_lane_out;
    logic [LANES-1:0]      w_lane_valid;

    // Gating with start guarantees a write and a job launch never share an edge.
    assign w_wr_ready = !rst && (r_state == S_IDLE) && (r_count < CW'(DEPTH)) && !start;
    assign w_start_ok = (r_state == S_IDLE) && start && (r_count != '0);

`ifdef SYSTOLIC_FEEDER_REPLAY_EN
    // A write offered in the done cycle empties the retained job instead of appending.
    assign w_clear = r_done && wr_valid && !start;
`else
    assign w_clear = 1'b0;
`endif

    assign w_wr_en    = wr_valid && w_wr_ready && !w_clear;
    assign w_last     = (r_step == SW'(r_count) + SW'(LANES - 1));
    assign w_step_sel = (r_state == S_IDLE) ? '0 : r_step;

    // Lane i shows element i of vector (step - i) while that vector index is in range.
    always_comb begin
        logic [SW-1:0] v;
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        v            = '0;
        w_lane_out   = '0;
        w_lane_valid = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_step_sel >= SW'(i)) begin
                v = w_step_sel - SW'(i);
                if (v < SW'(r_count)) begin
                    w_lane_out[i*DW +: DW] = r_mem[v[AW-1:0]][i*DW +: DW];
                    w_lane_valid[i]        = 1'b1;
                end
            end
        end
    end

    // NOTE: the vector buffer carries no reset; r_count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_count[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_step       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_lane_out   <= '0;
            r_lane_valid <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state      <= S_STREAM;
                        r_busy       <= 1'b1;
                        r_step       <= SW'(1);
                        r_lane_out   <= w_lane_out;
                        r_lane_valid <= w_lane_valid;
                    end else if (w_clear) begin
                        r_count <= '0;
                    end else if (w_wr_en) begin
                        r_count <= r_count + CW'(1);
                    end
                end
                S_STREAM: begin
                    if (w_last) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_step       <= '0;
                        r_lane_out   <= '0;
                        r_lane_valid <= '0;
`ifndef SYSTOLIC_FEEDER_REPLAY_EN
                        r_count      <= '0;
`endif
                    end else begin
                        r_step       <= r_step + SW'(1);
                        r_lane_out   <= w_lane_out;
                        r_lane_valid <= w_lane_valid;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_ready   = w_wr_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign lane_out   = r_lane_out;
    assign lane_valid = r_lane_valid;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: a job-level model checked every cycle, plus
// hand-computed timeline literals for skew, full buffer, ignored starts, reset and replay.
module tb_systolic_feeder;

    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_valid;
    logic                wr_ready;
    logic [LANES*DW-1:0] wr_data;
    logic                start;
    logic                busy;
    logic                done;
    logic [LANES*DW-1:0] lane_out;
    logic [LANES-1:0]    lane_valid;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    systolic_feeder #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .lane_out   (lane_out),
        .lane_valid (lane_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Job-level model: a buffer of vectors, a job length and the step being displayed.
    logic [LANES*DW-1:0] m_vec [DEPTH];
    int m_count, m_n, m_t;
    bit m_active, m_done, m_prev_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count = 0; m_n = 0; m_t = 0; m_active = 0; m_done = 0; m_prev_done = 0;
        end else begin
            m_prev_done = m_done;
            m_done      = 0;
            if (m_active) begin
                m_t++;
                if (m_t == m_n + LANES - 1) begin
                    m_active = 0;
                    m_done   = 1;
`ifndef SYSTOLIC_FEEDER_REPLAY_EN
                    m_count  = 0;
`endif
                end
            end else if (start && m_count > 0) begin
                m_active = 1; m_t = 0; m_n = m_count;
`ifdef SYSTOLIC_FEEDER_REPLAY_EN
            end else if (m_prev_done && wr_valid && !start) begin
                m_count = 0;
`endif
            end else if (wr_valid && !start && m_count < DEPTH) begin
                m_vec[m_count] = wr_data;
                m_count++;
            end
        end
    end

    always @(negedge clk) begin
        logic [LANES*DW-1:0] eo;
        logic [LANES-1:0]    ev;
        int v;
        if (chk_en) begin
            eo = '0; ev = '0;
            if (m_active) begin
                for (int i = 0; i < LANES; i++) begin
                    v = m_t - i;
                    if (v >= 0 && v < m_n) begin
                        eo[i*DW +: DW] = m_vec[v][i*DW +: DW];
                        ev[i] = 1'b1;
                    end
                end
            end
            check("model lane_out", lane_out, eo);
            check("model lane_valid", lane_valid, ev);
            check("model busy", busy, m_active);
            check("model done", done, m_done);
            check("model wr_ready", wr_ready, !rst && !m_active && m_count < DEPTH && !start);
        end
    end

    // Stimulus tasks start and end 2 time units after a rising edge.
    task automatic write_vec(input logic [LANES*DW-1:0] d);
        wr_valid = 1'b1; wr_data = d;
        @(posedge clk); #2;
        wr_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // k=1 is the first cycle after the call; k=-1 when done never came.
    task automatic wait_done(input int bound, output int k);
        k = -1;
        for (int j = 0; j < bound; j++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                k = j + 1;
                return;
            end
        end
    endtask

    task automatic end_job();
`ifdef SYSTOLIC_FEEDER_REPLAY_EN
        #1 wr_valid = 1'b1;
`endif
        @(posedge clk); #2;
        wr_valid = 1'b0;
    endtask

    logic [LANES*DW-1:0] skew_out [5];
    logic [LANES-1:0]    skew_v   [5];
    int k;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        skew_out[0] = {32'd0, 32'd0, 32'd0, 32'd1}; skew_v[0] = 4'b0001;
        skew_out[1] = {32'd0, 32'd0, 32'd2, 32'd5}; skew_v[1] = 4'b0011;
        skew_out[2] = {32'd0, 32'd3, 32'd6, 32'd0}; skew_v[2] = 4'b0110;
        skew_out[3] = {32'd4, 32'd7, 32'd0, 32'd0}; skew_v[3] = 4'b1100;
        skew_out[4] = {32'd8, 32'd0, 32'd0, 32'd0}; skew_v[4] = 4'b1000;

        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset lane_out", lane_out, '0);
        check("reset lane_valid", lane_valid, '0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset wr_ready", wr_ready, 1'b1);
        @(posedge clk); #2;

        // Skew: two vectors, lane3..lane0
        write_vec({32'd4, 32'd3, 32'd2, 32'd1});
        write_vec({32'd8, 32'd7, 32'd6, 32'd5});
        do_start();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("skew lane_out T+%0d", c + 1), lane_out, skew_out[c]);
            check($sformatf("skew lane_valid T+%0d", c + 1), lane_valid, skew_v[c]);
            check($sformatf("skew busy T+%0d", c + 1), busy, 1'b1);
        end
        @(negedge clk);
        check("skew done T+6", done, 1'b1);
        check("skew busy T+6", busy, 1'b0);
        check("skew lane_valid T+6", lane_valid, '0);
        end_job();

        // Full buffer, then a rejected ninth write
        for (int j = 0; j < DEPTH; j++)
            write_vec({32'(j*16+3), 32'(j*16+2), 32'(j*16+1), 32'(j*16)});
        #1 check("full wr_ready", wr_ready, 1'b0);
        write_vec({4{32'hdeadbeef}});
        do_start();
        wait_done(40, k);
        check("full done cycle", k, 12);
        end_job();

        // Start with an empty buffer is ignored
        do_start();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("empty start busy", busy, 1'b0);
            check("empty start done", done, 1'b0);
        end
        @(posedge clk); #2;

        // Start pulsed mid-stream of a 3-vector job leaves the timeline unchanged
        for (int j = 0; j < 3; j++)
            write_vec({32'(j+40), 32'(j+30), 32'(j+20), 32'(j+10)});
        do_start();
        @(posedge clk); #2;
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(40, k);
        check("mid start done cycle", k, 4);
        end_job();

        // Reset at T+3 of a 2-vector job
        write_vec({32'h13, 32'h12, 32'h11, 32'h10});
        write_vec({32'h23, 32'h22, 32'h21, 32'h20});
        do_start();
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst busy", busy, 1'b0);
        check("rst lane_valid", lane_valid, '0);
        check("rst lane_out", lane_out, '0);
        check("rst done", done, 1'b0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
        do_start();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post-rst start busy", busy, 1'b0);
            check("post-rst start done", done, 1'b0);
        end
        @(posedge clk); #2;

        // Replay: second start after done
        write_vec({32'h53, 32'h52, 32'h51, 32'h50});
        write_vec({32'h63, 32'h62, 32'h61, 32'h60});
        do_start();
        wait_done(40, k);
        check("replay first done", k, 6);
        @(posedge clk); #2;
        do_start();
`ifdef SYSTOLIC_FEEDER_REPLAY_EN
        wait_done(40, k);
        check("replay second done", k, 6);
`else
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("second start busy", busy, 1'b0);
            check("second start done", done, 1'b0);
        end
`endif
        @(posedge clk); #2;

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
